mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single main memory between the instruction cache (port I) and the data cache (port D).
- Sits between both caches' memory-side handshake (read/write request, data-ready, data-grabbed) and the main memory.
- Grants one requester at a time, round-robin, and holds the grant for one complete handshake.
- Routes address, write data and strobes to memory, and returns read data and ready to the granted requester only.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
i_address  in  ADDR_W  port I memory address
i_write_data  in  DATA_W  port I write data
i_read_mem  in  1  port I read request
i_write_mem  in  1  port I write request
i_data_grabbed  in  1  port I has consumed the ready/data
i_read_data  out  DATA_W  read data to port I
i_mem_data_ready  out  1  memory ready, port I view
d_address, d_write_data, d_read_mem, d_write_mem, d_data_grabbed  in  ADDR_W/DATA_W/1/1/1  port D, same meanings as port I
d_read_data  out  DATA_W  read data to port D
d_mem_data_ready  out  1  memory ready, port D view
mem_address  out  ADDR_W  to memory
mem_write_data  out  DATA_W  to memory
mem_read  out  1  to memory
mem_write  out  1  to memory
mem_data_grabbed  out  1  to memory
mem_data_ready  in  1  from memory
mem_read_data  in  DATA_W  from memory
busy  out  1  a grant is active
grant_d  out  1  1 = D granted, 0 = I granted; valid when busy = 1

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, priority pointer = D.
  - All outputs 0, including busy, grant_d, both ready outputs and both read-data outputs.
- A port "requests" when its read or write strobe is high.
- Requesters hold address, data and strobe stable until they see their ready and assert grabbed.
- States:
  - IDLE: memory-side outputs are 0. At a clock edge with any request, latch the grant:
    - only one port requesting: grant that port;
    - both requesting: grant the port named by the pointer.
    - Next state BUSY.
  - BUSY:
    - Drive mem_address, mem_write_data, mem_read and mem_write combinationally from the granted port.
    - If the granted port raises both strobes, forward write only (mem_read = 0).
    - Route mem_data_ready and mem_read_data to the granted port's ready and read-data outputs. The non-granted port sees ready = 0 and read data = 0.
    - Forward the granted port's grabbed signal to mem_data_grabbed.
    - When mem_data_ready = 1 and the granted port's grabbed = 1 at a clock edge, go to DRAIN.
  - DRAIN:
    - mem_read = 0, mem_write = 0, mem_data_grabbed = 1; ready to both ports = 0.
    - When mem_data_ready = 0, go to IDLE and set the pointer to the non-granted port.
- Latency: the grant takes effect one cycle after the request is first sampled in IDLE. Turnaround is at least 1 IDLE cycle between transactions.
- Fairness: under continuous contention, grants strictly alternate I, D, I, D...
- busy = 1 in BUSY and DRAIN; grant_d is held constant across both.
- Granted requester drops its strobe in BUSY before ready (protocol violation):
  - the arbiter stays in BUSY with mem strobes 0 and waits for ready plus grabbed;
  - there is no abort path.
- A request arriving during BUSY or DRAIN from the other port is not lost; it is serviced after return to IDLE.
- Reset mid-transaction: state returns to IDLE immediately and all strobes drop in the same instant. Main memory is reset by the same rst.

Decomposition:
- Shared package:
  - state enum {IDLE, BUSY, DRAIN} as 2-bit constants;
  - port-select constants PORT_I = 0, PORT_D = 1.
- One natural sub-module, mem_arb_mux: a purely combinational 2:1 mux of {address, write data, read, write, grabbed} selected by grant and gated by state. The FSM, pointer and return-path demux stay in the top module.

Test Plan:
- Reset: hold rst = 0 with both ports requesting → every output is 0. Release rst → first grant goes to D.
- Single I read, address 0x40, memory returns 0xDEADBEEF: i_read_data = 0xDEADBEEF with i_mem_data_ready = 1; d_mem_data_ready stays 0; busy deasserts after DRAIN.
- Contention: I and D both continuously reading 0x10 / 0x20 for 4 transactions → grant order D, I, D, I; mem_address sequence 0x20, 0x10, 0x20, 0x10.
- D write of 0x12345678 to 0x80 while I reads 0x84: mem_write = 1 with data 0x12345678 first; the I read follows only after mem_data_ready falls.
- Both strobes from D: mem_write = 1 and mem_read = 0 throughout BUSY.
- Assert rst = 0 in mid-BUSY while memory ready = 1 → mem_read, busy and both ready outputs drop immediately. After release, the pending request is re-granted from IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and debug view for the I/D cache memory arbiter.
// State codes are plain 2-bit constants so older tools and checkers can bind to them.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Snapshot of the arbiter's internal control state for checkers and debug.
    typedef struct packed {
        logic [1:0] state;
        logic       grantD;
        logic       ptrD;
    } arbDbg_t;

endpackage

// File: rtl/mem_arb_mux.sv
// Forward path of the arbiter: selects the granted port's request signals and
// gates them by arbiter state so memory sees nothing outside an active grant.
module mem_arb_mux
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [1:0]        state,
    input  logic              grantD,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [DATA_W-1:0] iWriteData,
    input  logic              iRead,
    input  logic              iWrite,
    input  logic              iGrabbed,
    input  logic [ADDR_W-1:0] dAddress,
    input  logic [DATA_W-1:0] dWriteData,
    input  logic              dRead,
    input  logic              dWrite,
    input  logic              dGrabbed,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memRead,
    output logic              memWrite,
    output logic              memGrabbed
);

    logic [ADDR_W-1:0] selAddress;
    logic [DATA_W-1:0] selWriteData;
    logic              selRead;
    logic              selWrite;
    logic              selGrabbed;

    assign selAddress   = (grantD == PORT_D) ? dAddress   : iAddress;
    assign selWriteData = (grantD == PORT_D) ? dWriteData : iWriteData;
    assign selRead      = (grantD == PORT_D) ? dRead      : iRead;
    assign selWrite     = (grantD == PORT_D) ? dWrite     : iWrite;
    assign selGrabbed   = (grantD == PORT_D) ? dGrabbed   : iGrabbed;

    always_comb begin
        memAddress   = '0;
        memWriteData = '0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        memGrabbed   = 1'b0;
        case (state)
            ST_BUSY: begin
                memAddress   = selAddress;
                memWriteData = selWriteData;
                // A port raising both strobes is treated as a write.
                memWrite     = selWrite;
                memRead      = selRead & ~selWrite;
                memGrabbed   = selGrabbed;
            end
            ST_DRAIN: begin
                // Keep grabbed asserted until memory lowers ready.
                memAddress   = selAddress;
                memWriteData = selWriteData;
                memGrabbed   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main memory between the instruction and data
// caches; a grant lasts one full ready/grabbed handshake plus a drain phase.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic              i_read_mem,
    input  logic              i_write_mem,
    input  logic              i_data_grabbed,
    output logic [DATA_W-1:0] i_read_data,
    output logic              i_mem_data_ready,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_write_data,
    input  logic              d_read_mem,
    input  logic              d_write_mem,
    input  logic              d_data_grabbed,
    output logic [DATA_W-1:0] d_read_data,
    output logic              d_mem_data_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_data_grabbed,
    input  logic              mem_data_ready,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              grant_d,
    output arbDbg_t           dbg
);

    // Handshake: a port requests while either strobe is high and keeps its
    // address/data/strobes stable until it sees ready; it then raises grabbed,
    // which is forwarded to memory, and memory lowers ready to end the transfer.

    logic [1:0] state;
    logic       grantD;
    logic       ptrD;
    logic       iReq;
    logic       dReq;
    logic       iRoute;
    logic       dRoute;

    assign iReq = i_read_mem | i_write_mem;
    assign dReq = d_read_mem | d_write_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            grantD <= PORT_I;
            ptrD   <= PORT_D;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iReq || dReq) begin
                        grantD <= (iReq && dReq) ? ptrD : dReq;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // mem_data_grabbed is the granted port's grabbed while busy.
                    if (mem_data_ready && mem_data_grabbed) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!mem_data_ready) begin
                        state <= ST_IDLE;
                        ptrD  <= ~grantD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_arb_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .state       (state),
        .grantD      (grantD),
        .iAddress    (i_address),
        .iWriteData  (i_write_data),
        .iRead       (i_read_mem),
        .iWrite      (i_write_mem),
        .iGrabbed    (i_data_grabbed),
        .dAddress    (d_address),
        .dWriteData  (d_write_data),
        .dRead       (d_read_mem),
        .dWrite      (d_write_mem),
        .dGrabbed    (d_data_grabbed),
        .memAddress  (mem_address),
        .memWriteData(mem_write_data),
        .memRead     (mem_read),
        .memWrite    (mem_write),
        .memGrabbed  (mem_data_grabbed)
    );

    // Return path reaches only the granted port, and only before the drain.
    assign iRoute = (state == ST_BUSY) && (grantD == PORT_I);
    assign dRoute = (state == ST_BUSY) && (grantD == PORT_D);

    assign i_mem_data_ready = iRoute & mem_data_ready;
    assign d_mem_data_ready = dRoute & mem_data_ready;
    assign i_read_data      = iRoute ? mem_read_data : '0;
    assign d_read_data      = dRoute ? mem_read_data : '0;

    assign busy    = (state != ST_IDLE);
    assign grant_d = busy & grantD;

    assign dbg.state  = state;
    assign dbg.grantD = grantD;
    assign dbg.ptrD   = ptrD;

endmodule
